// File: rtl/btisa_decode_exec.sv
// BTISA v0.1 registered decode/execute slice between ID and WB.
// Decodes one 9-trit instruction, runs the balanced-ternary ALU and PC adders.
module btisa_decode_exec #(
    parameter int TRIT_WIDTH = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [17:0]             instr,
    input  logic [2*TRIT_WIDTH-1:0] rs1_data,
    input  logic [2*TRIT_WIDTH-1:0] rs2_data,
    input  logic [15:0]             pc,
    output logic                    out_valid,
    output logic [3:0]              rd,
    output logic [3:0]              rs1,
    output logic [3:0]              rs2_imm,
    output logic                    reg_write,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    branch,
    output logic                    jump,
    output logic                    alu_src,
    output logic                    halt,
    output logic                    take_branch,
    output logic [2:0]              alu_op,
    output logic [2*TRIT_WIDTH-1:0] alu_result,
    output logic [1:0]              alu_carry,
    output logic                    zero_flag,
    output logic                    neg_flag,
    output logic [15:0]             pc_plus_one,
    output logic [15:0]             branch_target
);
    localparam int W = 2 * TRIT_WIDTH;

    typedef logic signed [4:0] tval_t;

    function automatic tval_t tv(input logic [1:0] t);
        unique case (t)
            2'b01:   return 5'sd1;
            2'b10:   return -5'sd1;
            default: return 5'sd0;
        endcase
    endfunction

    function automatic logic [1:0] te(input tval_t v);
        if (v > 5'sd0) return 2'b01;
        if (v < 5'sd0) return 2'b10;
        return 2'b00;
    endfunction

    // Full adder: returns {carry, sum}
    function automatic logic [3:0] fa(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        tval_t s;
        s = tv(a) + tv(b) + tv(c);
        if (s > 5'sd1) return {2'b01, te(s - 5'sd3)};
        if (s < -5'sd1) return {2'b10, te(s + 5'sd3)};
        return {2'b00, te(s)};
    endfunction

    tval_t      w_opv;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_branch;
    logic       w_jump;
    logic       w_alu_src;
    logic       w_halt;
    logic [2:0] w_alu_op;

    assign w_opv = 5'sd9 * tv(instr[17:16])
                 + 5'sd3 * tv(instr[15:14])
                 + tv(instr[13:12]);

    always_comb begin
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_alu_src   = 1'b0;
        w_halt      = 1'b0;
        w_alu_op    = 3'b000;
        unique case (1'b1)
            (w_opv == 5'sd1): w_reg_write = 1'b1;
            (w_opv == 5'sd2): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b001;
            end
            (w_opv == 5'sd3): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b010;
            end
            (w_opv == 5'sd4): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b011;
            end
            (w_opv == 5'sd5): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b100;
            end
            (w_opv == 5'sd6): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b101;
            end
            (w_opv == 5'sd7): begin
                w_reg_write = 1'b1;
                w_alu_op    = 3'b110;
            end
            (w_opv == 5'sd8): begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            (w_opv == -5'sd1): begin
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src   = 1'b1;
            end
            (w_opv == -5'sd2): begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            (w_opv == -5'sd3): begin
                w_branch = 1'b1;
                w_alu_op = 3'b001;
            end
            (w_opv == -5'sd4):  w_jump = 1'b1;
            (w_opv == -5'sd13): w_halt = 1'b1;
            default: ;
        endcase
    end

    logic [W-1:0] w_imm_pad;
    logic [15:0]  w_imm8;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_bx;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_res;
    logic [1:0]   w_cout;
    logic [1:0]   w_carry;
    logic         w_zero;
    logic         w_neg;

    // Balanced ternary needs no sign extension: padding with 0 trits keeps the value
    assign w_imm_pad = {{(W-4){1'b0}}, instr[3:0]};
    assign w_imm8    = {12'b0, instr[3:0]};

    always_comb begin
        logic [1:0] c;
        w_a  = '0;
        w_b  = '0;
        w_bx = '0;
        for (int i = 0; i < TRIT_WIDTH; i++) begin
            w_a[2*i +: 2] = te(tv(rs1_data[2*i +: 2]));
            w_b[2*i +: 2] = w_alu_src ? te(tv(w_imm_pad[2*i +: 2]))
                                      : te(tv(rs2_data[2*i +: 2]));
            w_bx[2*i +: 2] = (w_alu_op == 3'b001) ? te(-tv(w_b[2*i +: 2]))
                                                  : w_b[2*i +: 2];
        end
        c     = 2'b00;
        w_sum = '0;
        for (int i = 0; i < TRIT_WIDTH; i++)
            {c, w_sum[2*i +: 2]} = fa(w_a[2*i +: 2], w_bx[2*i +: 2], c);
        w_cout = c;
    end

    always_comb begin
        w_res   = w_sum;
        w_carry = 2'b00;
        unique case (w_alu_op)
            3'b000, 3'b001: w_carry = w_cout;
            3'b010: begin
                for (int i = 0; i < TRIT_WIDTH; i++)
                    w_res[2*i +: 2] = te(-tv(w_a[2*i +: 2]));
            end
            3'b011: begin
                for (int i = 0; i < TRIT_WIDTH; i++)
                    w_res[2*i +: 2] = (tv(w_a[2*i +: 2]) < tv(w_b[2*i +: 2]))
                                    ? w_a[2*i +: 2] : w_b[2*i +: 2];
            end
            3'b100: begin
                for (int i = 0; i < TRIT_WIDTH; i++)
                    w_res[2*i +: 2] = (tv(w_a[2*i +: 2]) > tv(w_b[2*i +: 2]))
                                    ? w_a[2*i +: 2] : w_b[2*i +: 2];
            end
            3'b101: begin
                w_res   = {w_a[W-3:0], 2'b00};
                w_carry = w_a[W-1 -: 2];
            end
            3'b110: begin
                w_res   = {2'b00, w_a[W-1:2]};
                w_carry = w_a[1:0];
            end
            3'b111: w_res = w_b;
        endcase
    end

    // Scan upward so the most significant nonzero trit decides the sign
    always_comb begin
        w_zero = (w_res == '0);
        w_neg  = 1'b0;
        for (int i = 0; i < TRIT_WIDTH; i++)
            if (w_res[2*i +: 2] != 2'b00)
                w_neg = (w_res[2*i +: 2] == 2'b10);
    end

    logic [15:0] w_pc1;
    logic [15:0] w_bt;

    always_comb begin
        logic [1:0] c1;
        logic [1:0] c2;
        c1    = 2'b01;
        c2    = 2'b00;
        w_pc1 = '0;
        w_bt  = '0;
        for (int i = 0; i < 8; i++) begin
            {c1, w_pc1[2*i +: 2]} = fa(pc[2*i +: 2], 2'b00, c1);
            {c2, w_bt[2*i +: 2]}  = fa(pc[2*i +: 2], w_imm8[2*i +: 2], c2);
        end
    end

    logic         r_out_valid;
    logic [3:0]   r_rd;
    logic [3:0]   r_rs1;
    logic [3:0]   r_rs2_imm;
    logic         r_reg_write;
    logic         r_mem_read;
    logic         r_mem_write;
    logic         r_branch;
    logic         r_jump;
    logic         r_alu_src;
    logic         r_halt;
    logic         r_take_branch;
    logic [2:0]   r_alu_op;
    logic [W-1:0] r_alu_result;
    logic [1:0]   r_alu_carry;
    logic         r_zero_flag;
    logic         r_neg_flag;
    logic [15:0]  r_pc_plus_one;
    logic [15:0]  r_branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_rd            <= '0;
            r_rs1           <= '0;
            r_rs2_imm       <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_branch        <= 1'b0;
            r_jump          <= 1'b0;
            r_alu_src       <= 1'b0;
            r_halt          <= 1'b0;
            r_take_branch   <= 1'b0;
            r_alu_op        <= '0;
            r_alu_result    <= '0;
            r_alu_carry     <= '0;
            r_zero_flag     <= 1'b0;
            r_neg_flag      <= 1'b0;
            r_pc_plus_one   <= '0;
            r_branch_target <= '0;
        end else begin
            r_out_valid   <= in_valid;
            r_reg_write   <= in_valid & w_reg_write;
            r_mem_read    <= in_valid & w_mem_read;
            r_mem_write   <= in_valid & w_mem_write;
            r_branch      <= in_valid & w_branch;
            r_jump        <= in_valid & w_jump;
            r_halt        <= in_valid & w_halt;
            r_take_branch <= in_valid & w_branch & w_zero;
            if (in_valid) begin
                r_rd            <= instr[11:8];
                r_rs1           <= instr[7:4];
                r_rs2_imm       <= instr[3:0];
                r_alu_src       <= w_alu_src;
                r_alu_op        <= w_alu_op;
                r_alu_result    <= w_res;
                r_alu_carry     <= w_carry;
                r_zero_flag     <= w_zero;
                r_neg_flag      <= w_neg;
                r_pc_plus_one   <= w_pc1;
                r_branch_target <= w_bt;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign rd            = r_rd;
    assign rs1           = r_rs1;
    assign rs2_imm       = r_rs2_imm;
    assign reg_write     = r_reg_write;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign branch        = r_branch;
    assign jump          = r_jump;
    assign alu_src       = r_alu_src;
    assign halt          = r_halt;
    assign take_branch   = r_take_branch;
    assign alu_op        = r_alu_op;
    assign alu_result    = r_alu_result;
    assign alu_carry     = r_alu_carry;
    assign zero_flag     = r_zero_flag;
    assign neg_flag      = r_neg_flag;
    assign pc_plus_one   = r_pc_plus_one;
    assign branch_target = r_branch_target;

endmodule

// File: tb/tb_btisa_decode_exec.sv
// Bench for btisa_decode_exec: directed vector table plus random
// instructions checked against an integer-arithmetic reference model.
module tb_btisa_decode_exec;
    localparam longint N3 = 64'sd7625597484987;
    localparam longint H  = 64'sd3812798742493;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [17:0] instr;
    logic [53:0] rs1_data;
    logic [53:0] rs2_data;
    logic [15:0] pc;
    logic        out_valid;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        halt;
    logic        take_branch;
    logic [2:0]  alu_op;
    logic [53:0] alu_result;
    logic [1:0]  alu_carry;
    logic        zero_flag;
    logic        neg_flag;
    logic [15:0] pc_plus_one;
    logic [15:0] branch_target;

    btisa_decode_exec #(.TRIT_WIDTH(27)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
        .out_valid(out_valid), .rd(rd), .rs1(rs1), .rs2_imm(rs2_imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_src(alu_src), .halt(halt),
        .take_branch(take_branch), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .zero_flag(zero_flag), .neg_flag(neg_flag),
        .pc_plus_one(pc_plus_one), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ov;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  imm;
        logic        rw, mr, mw, br, jp, src, hl, tk;
        logic [2:0]  op;
        logic [53:0] res;
        logic [1:0]  car;
        logic        z, n;
        logic [15:0] p1;
        logic [15:0] bt;
    } mdl_t;

    typedef struct {
        bit     v;
        int     op;
        int     imm;
        longint a;
        longint b;
        int     pc;
        longint r;
        int     c;
        bit     z, n, rw, hl, tk, ov;
        int     p1;
        int     bt;
    } vec_t;

    mdl_t m;
    vec_t tbl[12];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic int trit(logic [63:0] v, int i);
        logic [1:0] t;
        t = v[2*i +: 2];
        if (t == 2'b01) return 1;
        if (t == 2'b10) return -1;
        return 0;
    endfunction

    function automatic longint to_int(logic [63:0] v, int n);
        longint r;
        r = 0;
        for (int i = n - 1; i >= 0; i--) r = r * 3 + trit(v, i);
        return r;
    endfunction

    // Balanced-ternary encode of v into n trits, wrapping mod 3^n
    function automatic logic [63:0] enc(longint v, int n);
        logic [63:0] r;
        longint x, d;
        r = '0;
        x = v;
        for (int i = 0; i < n; i++) begin
            d = x % 3;
            if (d == 2) d = -1;
            if (d == -2) d = 1;
            r[2*i +: 2] = (d == 1) ? 2'b01 : (d == -1) ? 2'b10 : 2'b00;
            x = (x - d) / 3;
        end
        return r;
    endfunction

    function automatic logic [17:0] mk(int op, int f_rd, int f_rs1, int im);
        logic [63:0] t0, t1, t2, t3;
        t0 = enc(op, 3);
        t1 = enc(f_rd, 2);
        t2 = enc(f_rs1, 2);
        t3 = enc(im, 2);
        return {t0[5:0], t1[3:0], t2[3:0], t3[3:0]};
    endfunction

    function automatic mdl_t step(mdl_t mi, logic v, logic [17:0] ins,
                                  logic [53:0] ad, logic [53:0] bd,
                                  logic [15:0] p);
        mdl_t o;
        longint a, b, r;
        int c, op;
        logic [63:0] bv, t;
        o = mi;
        o.ov = v;
        {o.rw, o.mr, o.mw, o.br, o.jp, o.hl, o.tk} = '0;
        if (!v) return o;
        op = int'(to_int({46'b0, ins[17:12]}, 3));
        o.rd = ins[11:8];
        o.rs1 = ins[7:4];
        o.imm = ins[3:0];
        o.src = 1'b0;
        o.op = 3'd0;
        case (op)
            1:   o.rw = 1'b1;
            2:   begin o.rw = 1'b1; o.op = 3'd1; end
            3:   begin o.rw = 1'b1; o.op = 3'd2; end
            4:   begin o.rw = 1'b1; o.op = 3'd3; end
            5:   begin o.rw = 1'b1; o.op = 3'd4; end
            6:   begin o.rw = 1'b1; o.op = 3'd5; end
            7:   begin o.rw = 1'b1; o.op = 3'd6; end
            8:   begin o.rw = 1'b1; o.src = 1'b1; end
            -1:  begin o.rw = 1'b1; o.mr = 1'b1; o.src = 1'b1; end
            -2:  begin o.mw = 1'b1; o.src = 1'b1; end
            -3:  begin o.br = 1'b1; o.op = 3'd1; end
            -4:  o.jp = 1'b1;
            -13: o.hl = 1'b1;
            default: ;
        endcase
        bv = o.src ? {60'b0, ins[3:0]} : {10'b0, bd};
        a = to_int({10'b0, ad}, 27);
        b = to_int(bv, 27);
        c = 0;
        r = 0;
        case (o.op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = -a;
            3'd3, 3'd4: begin
                for (int i = 26; i >= 0; i--) begin
                    int x, y;
                    x = trit({10'b0, ad}, i);
                    y = trit(bv, i);
                    r = r * 3 + ((o.op == 3'd3) ? ((x < y) ? x : y)
                                               : ((x > y) ? x : y));
                end
            end
            3'd5: r = 3 * a;
            3'd6: begin
                c = trit({10'b0, ad}, 0);
                r = (a - c) / 3;
            end
            default: r = b;
        endcase
        if (o.op == 3'd0 || o.op == 3'd1 || o.op == 3'd5) begin
            if (r > H) begin r = r - N3; c = 1; end
            else if (r < -H) begin r = r + N3; c = -1; end
        end
        t = enc(r, 27);
        o.res = t[53:0];
        t = enc(c, 1);
        o.car = t[1:0];
        o.z = (r == 0);
        o.n = (r < 0);
        o.tk = o.br & o.z;
        t = enc(to_int({48'b0, p}, 8) + 1, 8);
        o.p1 = t[15:0];
        t = enc(to_int({48'b0, p}, 8) + to_int({60'b0, ins[3:0]}, 2), 8);
        o.bt = t[15:0];
        return o;
    endfunction

    task automatic chk(input string tg, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %0h, expected %0h", tg, nm, act, exp);
        end
    endtask

    task automatic check_all(input string tg);
        chk(tg, "out_valid", out_valid, m.ov);
        chk(tg, "rd", rd, m.rd);
        chk(tg, "rs1", rs1, m.rs1);
        chk(tg, "rs2_imm", rs2_imm, m.imm);
        chk(tg, "reg_write", reg_write, m.rw);
        chk(tg, "mem_read", mem_read, m.mr);
        chk(tg, "mem_write", mem_write, m.mw);
        chk(tg, "branch", branch, m.br);
        chk(tg, "jump", jump, m.jp);
        chk(tg, "alu_src", alu_src, m.src);
        chk(tg, "halt", halt, m.hl);
        chk(tg, "take_branch", take_branch, m.tk);
        chk(tg, "alu_op", alu_op, m.op);
        chk(tg, "alu_result", alu_result, m.res);
        chk(tg, "alu_carry", alu_carry, m.car);
        chk(tg, "zero_flag", zero_flag, m.z);
        chk(tg, "neg_flag", neg_flag, m.n);
        chk(tg, "pc_plus_one", pc_plus_one, m.p1);
        chk(tg, "branch_target", branch_target, m.bt);
    endtask

    task automatic apply(input logic v, input logic [17:0] ins,
                         input logic [53:0] a, input logic [53:0] b,
                         input logic [15:0] p, input string tg);
        in_valid = v;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        pc       = p;
        m = step(m, v, ins, a, b, p);
        @(posedge clk);
        #1;
        n_vec++;
        check_all(tg);
    endtask

    function automatic logic [53:0] rnd_data();
        logic [63:0] t, u;
        case ($urandom_range(0, 3))
            0: t = {$urandom, $urandom};
            1: t = enc(int'($urandom_range(0, 100)) - 50, 27);
            2: t = enc(($urandom_range(0, 1) != 0) ? H : -H, 27);
            default: begin
                u = {$urandom, $urandom};
                t = enc(longint'(u % 64'd7625597484987) - H, 27);
            end
        endcase
        return t[53:0];
    endfunction

    initial begin
        //           v  op imm  a    b    pc    r   c  z n rw hl tk ov  p1     bt
        tbl[0]  = '{1,  1,  0,  5,   7,   0,   12, 0, 0,0,1, 0, 0, 1,  1,     0};
        tbl[1]  = '{1,  2,  0, -40, -40,  3,    0, 0, 1,0,1, 0, 0, 1,  4,     3};
        tbl[2]  = '{1, -3,  1,  9,   9,   5,    0, 0, 1,0,0, 0, 1, 1,  6,     6};
        tbl[3]  = '{1, -3,  0,  3,   4,   5,   -1, 0, 0,1,0, 0, 0, 1,  6,     5};
        tbl[4]  = '{1,  8, -2,  10,  999, 20,   8, 0, 0,0,1, 0, 0, 1,  21,    18};
        tbl[5]  = '{1,  1,  0,  H,   H,   0,   -1, 1, 0,1,1, 0, 0, 1,  1,     0};
        tbl[6]  = '{1,  6,  0,  7,   0,   0,   21, 0, 0,0,1, 0, 0, 1,  1,     0};
        tbl[7]  = '{1,  7,  0,  7,   0,   0,    2, 1, 0,0,1, 0, 0, 1,  1,     0};
        tbl[8]  = '{1,  9,  0,  1,   1,   0,    2, 0, 0,0,0, 0, 0, 1,  1,     0};
        tbl[9]  = '{1, -13, 0,  1,   1,   7,    2, 0, 0,0,0, 1, 0, 1,  8,     7};
        tbl[10] = '{0,  1,  3,  50,  50,  9,    2, 0, 0,0,0, 0, 0, 0,  8,     7};
        tbl[11] = '{1,  1,  1,  0,   0,   3280, 0, 0, 1,0,1, 0, 0, 1, -3280, -3280};

        m        = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        rs1_data = '0;
        rs2_data = '0;
        pc       = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            vec_t t;
            logic [63:0] ea, eb, ep;
            string tg;
            t  = tbl[i];
            ea = enc(t.a, 27);
            eb = enc(t.b, 27);
            ep = enc(t.pc, 8);
            tg = $sformatf("vec%0d", i);
            apply(t.v, mk(t.op, i % 9 - 4, 4 - i % 9, t.imm),
                  ea[53:0], eb[53:0], ep[15:0], tg);
            chk(tg, "res", to_int({10'b0, alu_result}, 27), t.r);
            chk(tg, "carry", to_int({62'b0, alu_carry}, 1), t.c);
            chk(tg, "zero", zero_flag, t.z);
            chk(tg, "neg", neg_flag, t.n);
            chk(tg, "rw", reg_write, t.rw);
            chk(tg, "halt", halt, t.hl);
            chk(tg, "take", take_branch, t.tk);
            chk(tg, "ov", out_valid, t.ov);
            chk(tg, "pc1", to_int({48'b0, pc_plus_one}, 8), t.p1);
            chk(tg, "bt", to_int({48'b0, branch_target}, 8), t.bt);
        end

        for (int i = 0; i < 400; i++) begin
            logic [63:0] u;
            logic [17:0] ins;
            u = {$urandom, $urandom};
            if ($urandom_range(0, 1) != 0)
                ins = u[17:0];
            else
                ins = mk(int'($urandom_range(0, 26)) - 13,
                         int'($urandom_range(0, 8)) - 4,
                         int'($urandom_range(0, 8)) - 4,
                         int'($urandom_range(0, 8)) - 4);
            apply($urandom_range(0, 4) != 0, ins, rnd_data(), rnd_data(),
                  u[47:32], "rand");
        end

        begin
            logic [63:0] ea, eb;
            ea = enc(5, 27);
            eb = enc(7, 27);
            in_valid = 1'b1;
            instr    = mk(1, 1, 1, 0);
            rs1_data = ea[53:0];
            rs2_data = eb[53:0];
            pc       = '0;
            #2;
            rst_n = 1'b0;
            #1;
            m = '0;
            n_vec++;
            check_all("rst_async");
            @(posedge clk);
            #1;
            n_vec++;
            check_all("rst_hold");
            rst_n = 1'b1;
            apply(1'b1, mk(1, 1, 1, 0), ea[53:0], eb[53:0], 16'h0, "post_rst");
            chk("post_rst", "res", to_int({10'b0, alu_result}, 27), 12);
            chk("post_rst", "rw", reg_write, 1'b1);
            chk("post_rst", "ov", out_valid, 1'b1);
            chk("post_rst", "carry", alu_carry, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
